// File: rtl/lsu_multicycle.sv
// lsu_multicycle: multi-cycle load/store unit between the execute stage and a handshaked data bus.
// Optional macro MISALIGN_SPLIT_EN: misaligned accesses are performed (two beats when crossing a bus word) instead of faulting.
module lsu_multicycle #(
  parameter int BUS_BYTES = 4,
  parameter int ADDR_W    = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             mem_op,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   rsp_fault,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic [BUS_BYTES-1:0]   bus_be,
  output logic [8*BUS_BYTES-1:0] bus_wdata,
  input  logic                   bus_ack,
  input  logic [8*BUS_BYTES-1:0] bus_rdata
);
  localparam int OFF = $clog2(BUS_BYTES);
  localparam int DW  = 8 * BUS_BYTES;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
`ifdef MISALIGN_SPLIT_EN
    S_GAP   = 3'd3,
    S_BEAT1 = 3'd4,
`endif
    S_RESP  = 3'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 bus_req_q, bus_req_d;
  logic                 bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]    bus_addr_q, bus_addr_d;
  logic [BUS_BYTES-1:0] bus_be_q, bus_be_d;
  logic [DW-1:0]        bus_wdata_q, bus_wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_fault_q, rsp_fault_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic [1:0]           sz_q, sz_d;
  logic                 uns_q, uns_d;
  logic                 st_q, st_d;
  logic [OFF-1:0]       off_q, off_d;

  logic [7:0]           op_n;
  logic [1:0]           sz_in;
  logic                 uns_in, st_in, noop_in;
  logic [OFF-1:0]       off_in;
  logic [31:0]          lo_cap;
  logic                 unused_addr;

  // size code: 0 = byte, 1 = half, 2 = word
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] r, input logic [1:0] sz, input logic uns);
    case (sz)
      2'd0:    extend = {{24{r[7] & ~uns}}, r[7:0]};
      2'd1:    extend = {{16{r[15] & ~uns}}, r[15:0]};
      default: extend = r;
    endcase
  endfunction

  assign op_n        = ~mem_op;
  assign off_in      = addr[OFF-1:0];
  assign unused_addr = ^addr[31:ADDR_W+OFF];
  assign lo_cap      = 32'(bus_rdata >> {off_q, 3'b000});

  always_comb begin
    sz_in   = 2'd0;
    uns_in  = 1'b0;
    st_in   = 1'b0;
    noop_in = 1'b0;
    if (op_n[7]) sz_in = 2'd0;
    else if (op_n[6]) sz_in = 2'd1;
    else if (op_n[5]) sz_in = 2'd2;
    else if (op_n[4]) begin sz_in = 2'd0; uns_in = 1'b1; end
    else if (op_n[3]) begin sz_in = 2'd1; uns_in = 1'b1; end
    else if (op_n[2]) begin sz_in = 2'd0; st_in = 1'b1; end
    else if (op_n[1]) begin sz_in = 2'd1; st_in = 1'b1; end
    else if (op_n[0]) begin sz_in = 2'd2; st_in = 1'b1; end
    else noop_in = 1'b1;
  end

`ifdef MISALIGN_SPLIT_EN
  localparam int SW = OFF + 2;
  logic           cross_in, cross_q, cross_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    res_q, res_d;
  logic [31:0]    hi_cap;
  logic [OFF:0]   nlo_q;

  assign cross_in = ({2'b00, off_in} + (SW'(1) << sz_in)) > SW'(BUS_BYTES);
  // bytes already delivered by beat 0; beat 1 continues from there at lane 0
  assign nlo_q    = (OFF+1)'(BUS_BYTES) - {1'b0, off_q};
  assign hi_cap   = 32'(bus_rdata << {nlo_q, 3'b000});
`else
  logic mis_in;
  assign mis_in = (sz_in == 2'd1 && addr[0]) || (sz_in == 2'd2 && addr[1:0] != 2'b00);
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_fault_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    sz_d        = sz_q;
    uns_d       = uns_q;
    st_d        = st_q;
    off_d       = off_q;
`ifdef MISALIGN_SPLIT_EN
    cross_d     = cross_q;
    wdata_d     = wdata_q;
    res_d       = res_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          sz_d  = sz_in;
          uns_d = uns_in;
          st_d  = st_in;
          off_d = off_in;
`ifdef MISALIGN_SPLIT_EN
          cross_d = cross_in;
          wdata_d = wdata;
`endif
          if (noop_in) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
          end
`ifndef MISALIGN_SPLIT_EN
          else if (mis_in) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_data_d  = '0;
          end
`endif
          else begin
            state_d     = S_BEAT0;
            bus_req_d   = 1'b1;
            bus_we_d    = st_in;
            bus_addr_d  = addr[ADDR_W+OFF-1:OFF];
            bus_be_d    = BUS_BYTES'(size_mask(sz_in)) << off_in;
            bus_wdata_d = DW'(wdata) << {off_in, 3'b000};
          end
        end
      end
      S_BEAT0: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
`ifdef MISALIGN_SPLIT_EN
          if (cross_q) begin
            state_d = S_GAP;
            res_d   = lo_cap;
          end else
`endif
          begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = st_q ? 32'h0 : extend(lo_cap, sz_q, uns_q);
          end
        end
      end
`ifdef MISALIGN_SPLIT_EN
      S_GAP: begin
        state_d     = S_BEAT1;
        bus_req_d   = 1'b1;
        bus_addr_d  = bus_addr_q + 1'b1;
        bus_be_d    = BUS_BYTES'(size_mask(sz_q)) >> nlo_q;
        bus_wdata_d = DW'(wdata_q) >> {nlo_q, 3'b000};
      end
      S_BEAT1: begin
        if (bus_ack) begin
          bus_req_d   = 1'b0;
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = st_q ? 32'h0 : extend(res_q | hi_cap, sz_q, uns_q);
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_data_q  <= '0;
      sz_q        <= 2'd0;
      uns_q       <= 1'b0;
      st_q        <= 1'b0;
      off_q       <= '0;
`ifdef MISALIGN_SPLIT_EN
      cross_q     <= 1'b0;
      wdata_q     <= '0;
      res_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_data_q  <= rsp_data_d;
      sz_q        <= sz_d;
      uns_q       <= uns_d;
      st_q        <= st_d;
      off_q       <= off_d;
`ifdef MISALIGN_SPLIT_EN
      cross_q     <= cross_d;
      wdata_q     <= wdata_d;
      res_q       <= res_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_data  = rsp_data_q;

endmodule
